// File: rtl/carregador_memoria.sv
// Program loader: streams (func, val) words into a 16-entry program RAM, then releases the CPU.
// Fetch is combinational; state, run, in_ready, words_loaded and erro are registered.
module carregador_memoria #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int FW    = 4,
   parameter int VW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [FW-1:0] in_func,
   input  logic [VW-1:0] in_val,
   input  logic          in_last,
   input  logic [AW-1:0] endereco,
   output logic [FW-1:0] funcsaidaMemory,
   output logic [VW-1:0] valMemory,
   output logic          run,
   output logic [AW:0]   words_loaded,
   output logic          erro
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam logic [AW:0] ONE      = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH-1);

   state_t state_q, state_d;
   logic [AW:0] wl_q, wl_d;
   logic erro_q, erro_d;
   logic run_q, run_d;
   logic rdy_q, rdy_d;
   logic wr_en;
   logic fetch_ok;
   logic [FW+VW-1:0] rd_word;
   logic [FW+VW-1:0] mem_q [DEPTH];

   always_comb begin
      state_d = state_q;
      wl_d    = wl_q;
      erro_d  = erro_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               wl_d    = '0;
            end
         end
         LOAD: begin
            if (in_valid && rdy_q) begin
               wr_en = 1'b1;
               wl_d  = wl_q + ONE;
               // The 16th word ends the session even without in_last.
               if (in_last || (wl_q == LAST_IDX)) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (start) begin
               state_d = LOAD;
               wl_d    = '0;
               erro_d  = 1'b0;
            end else if (in_valid) begin
               erro_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      run_d = (state_d == RUN);
      rdy_d = (state_d == LOAD) && (wl_d < DEPTH_W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wl_q    <= '0;
         erro_q  <= 1'b0;
         run_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wl_q    <= wl_d;
         erro_q  <= erro_d;
         run_q   <= run_d;
         rdy_q   <= rdy_d;
      end
   end

   // RAM is never cleared; stale words stay hidden by the fetch gate below.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wl_q[AW-1:0]] <= {in_func, in_val};
      end
   end

   always_comb begin
      fetch_ok        = (state_q == RUN) && ({1'b0, endereco} < wl_q);
      rd_word         = fetch_ok ? mem_q[endereco] : '0;
      funcsaidaMemory = rd_word[FW+VW-1:VW];
      valMemory       = rd_word[VW-1:0];
   end

   assign in_ready     = rdy_q;
   assign run          = run_q;
   assign words_loaded = wl_q;
   assign erro         = erro_q;

endmodule

// File: tb/tb_carregador_memoria.sv
// Scoreboard bench for carregador_memoria: stimulus pushes expected snapshots, a negedge monitor compares.
module tb_carregador_memoria;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_func = '0;
   logic [3:0] in_val = '0;
   logic       in_last = 1'b0;
   logic [3:0] endereco = '0;
   logic [3:0] funcsaidaMemory;
   logic [3:0] valMemory;
   logic       run;
   logic [4:0] words_loaded;
   logic       erro;

   // Snapshot layout: {run, in_ready, words_loaded[4:0], erro, func[3:0], val[3:0]}
   logic [15:0] exp_q [$];
   string       name_q [$];
   logic        chk_vld = 1'b0;
   int          n_pass = 0;
   int          n_total = 0;

   carregador_memoria dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_func(in_func), .in_val(in_val), .in_last(in_last),
      .endereco(endereco),
      .funcsaidaMemory(funcsaidaMemory), .valMemory(valMemory),
      .run(run), .words_loaded(words_loaded), .erro(erro)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_vld) begin
         logic [15:0] act;
         logic [15:0] expv;
         string       nm;
         act = {run, in_ready, words_loaded, erro, funcsaidaMemory, valMemory};
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: observed %h with no expectation queued", act);
         end else begin
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (act === expv) n_pass++;
            else $display("FAIL %s: got run=%b rdy=%b wl=%0d erro=%b func=%0d val=%0d, want run=%b rdy=%b wl=%0d erro=%b func=%0d val=%0d",
                          nm, act[15], act[14], act[13:9], act[8], act[7:4], act[3:0],
                          expv[15], expv[14], expv[13:9], expv[8], expv[7:4], expv[3:0]);
         end
      end
   end

   task automatic drive(input logic r, input logic st, input logic v,
                        input int f, input int val, input logic last);
      @(posedge clk);
      #1;
      rst      = r;
      start    = st;
      in_valid = v;
      in_func  = 4'(f);
      in_val   = 4'(val);
      in_last  = last;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // Samples on the negedge of the cycle whose inputs were just driven.
   task automatic check(input string nm, input int addr, input logic e_run, input logic e_rdy,
                        input int e_wl, input logic e_err, input int e_f, input int e_v);
      endereco = 4'(addr);
      exp_q.push_back({e_run, e_rdy, 5'(e_wl), e_err, 4'(e_f), 4'(e_v)});
      name_q.push_back(nm);
      chk_vld = 1'b1;
      @(negedge clk);
      #1;
      chk_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle
      drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle();
      check("reset_state", 0, 0, 0, 0, 0, 0, 0);
      repeat (3) idle();
      idle();
      check("idle_5cyc", 0, 0, 0, 0, 0, 0, 0);

      // Short program
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      check("start_cycle_still_idle", 0, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 1, 3, 1'b0);
      check("short_w0", 0, 0, 1, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 2, 5, 1'b0);
      check("short_w1", 0, 0, 1, 1, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 4, 7, 1'b1);
      check("short_w2_last", 0, 0, 1, 2, 0, 0, 0);
      idle();
      check("short_fetch0", 0, 1, 0, 3, 0, 1, 3);
      idle();
      check("short_fetch1", 1, 1, 0, 3, 0, 2, 5);
      idle();
      check("short_fetch2", 2, 1, 0, 3, 0, 4, 7);
      idle();
      check("short_fetch3_nop", 3, 1, 0, 3, 0, 0, 0);

      // Error in RUN, then reload
      drive(1'b0, 1'b0, 1'b1, 9, 0, 1'b0);
      check("err_offer_cycle", 0, 1, 0, 3, 0, 1, 3);
      idle();
      check("err_set_fetch0", 0, 1, 0, 3, 1, 1, 3);
      idle();
      check("err_sticky_fetch3", 3, 1, 0, 3, 1, 0, 0);
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      check("reload_start_cycle", 0, 1, 0, 3, 1, 1, 3);
      idle();
      check("reload_in_load", 0, 0, 1, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 6, 6, 1'b1);
      check("reload_w0", 0, 0, 1, 0, 0, 0, 0);
      idle();
      check("reload_fetch0", 0, 1, 0, 1, 0, 6, 6);
      idle();
      check("reload_fetch1_gated", 1, 1, 0, 1, 0, 0, 0);

      // Full memory
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, i, 15 - i, 1'b0);
         if (i == 0)  check("full_w0", 0, 0, 1, 0, 0, 0, 0);
         if (i == 15) check("full_w15", 0, 0, 1, 15, 0, 0, 0);
      end
      idle();
      check("full_fetch15", 15, 1, 0, 16, 0, 15, 0);
      idle();
      check("full_fetch0", 0, 1, 0, 16, 0, 0, 15);
      idle();
      check("full_fetch7", 7, 1, 0, 16, 0, 7, 8);

      // Backpressure and gaps
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 3, 1, 1'b0);
      check("gap_v0", 0, 0, 1, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 5, 5, 1'b1);
      check("gap_idle0", 0, 0, 1, 1, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 7, 2, 1'b0);
      check("gap_v1", 0, 0, 1, 1, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 5, 5, 1'b1);
      check("gap_idle1", 0, 0, 1, 2, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 8, 8, 1'b1);
      check("gap_v2_last", 0, 0, 1, 2, 0, 0, 0);
      idle();
      check("gap_fetch0", 0, 1, 0, 3, 0, 3, 1);
      idle();
      check("gap_fetch1", 1, 1, 0, 3, 0, 7, 2);
      idle();
      check("gap_fetch2", 2, 1, 0, 3, 0, 8, 8);

      // Reset mid-load
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1, 1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 2, 2, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 3, 3, 1'b0);
      check("rst_mid_before", 0, 0, 1, 2, 0, 0, 0);
      idle();
      check("rst_mid_after", 0, 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 9, 9, 1'b0);
      check("idle_valid_cycle", 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("idle_valid_no_err", 0, 0, 0, 0, 0, 0, 0);

      idle();
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
